// File: rtl/imem_dmem_arbiter_pkg.sv
// rtl/imem_dmem_arbiter_pkg.sv - shared types and helpers for the IF/D memory arbiter
// Purpose: return-owner tag encoding, streak counter width, word-address helper.
// Ports: none (package imem_dmem_arb_pkg).
package imem_dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int STREAK_W = 4;

  // Word index of a byte address: bits [aw+1:2], zero-extended to 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] addr, input int aw);
    return (addr >> 2) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// rtl/imem_dmem_arbiter_if.sv - bus bundle between fetch/LSU, arbiter and memory
// Purpose: groups the IF request/return, D request/return and memory signals.
// Modports: slave = arbiter view, master = core + memory view.
// Optional: IMEM_DMEM_ARBITER_ALIGN_CHECK_EN adds if_err / d_err.
interface imem_dmem_arbiter_if #(
  parameter int AW = 8
);
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

`ifdef IMEM_DMEM_ARBITER_ALIGN_CHECK_EN
  logic          if_err;
  logic          d_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
`else
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
`endif

endinterface

// File: rtl/imem_dmem_arbiter_streak_cnt.sv
// rtl/imem_dmem_arbiter_streak_cnt.sv - saturating fairness counter for the arbiter
// Purpose: counts consecutive D grants while IF waits; at_limit forces an IF win.
// Ports: clk, reset (async, active-high), inc, clr (wins over inc), limit, at_limit.
module arb_streak_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         at_limit
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - per-cycle arbiter sharing one sync-read memory between IF and D
// Purpose: one grant per cycle (D preferred, IF forced after MAX_STREAK D wins),
//          drive the memory on the grant cycle, route read data back one cycle later.
// Ports: clk, reset (async, active-high), bus (imem_dmem_arbiter_if.slave):
//          if_req/if_addr -> if_gnt, if_rvalid/if_rdata
//          d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid/d_rdata
//          mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
// Optional: IMEM_DMEM_ARBITER_ALIGN_CHECK_EN adds if_err/d_err and suppresses
//           misaligned accesses.
module imem_dmem_arbiter #(
  parameter int AW         = 8,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_dmem_arbiter_if.slave    bus
);
  import imem_dmem_arb_pkg::*;

  logic        at_limit;
  logic        if_gnt;
  logic        d_gnt;
  logic        any_gnt;
  logic [31:0] granted_addr;
  logic        misalign;
  owner_e      tag;
  owner_e      tag_next;
  logic        if_bad;
  logic        d_bad;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic [31:0] if_rdata_now;
  logic [31:0] d_rdata_now;

  // D wins unless IF has been waiting through MAX_STREAK D grants.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (bus.d_req && (!bus.if_req || !at_limit)) begin
      d_gnt = 1'b1;
    end else if (bus.if_req) begin
      if_gnt = 1'b1;
    end
  end

  assign any_gnt      = if_gnt | d_gnt;
  assign granted_addr = d_gnt ? bus.d_addr : bus.if_addr;

  arb_streak_cnt #(
    .W (STREAK_W)
  ) u_streak (
    .clk      (clk),
    .reset    (reset),
    .inc      (d_gnt & bus.if_req),
    .clr      (if_gnt | ~bus.if_req),
    .limit    (STREAK_W'(MAX_STREAK)),
    .at_limit (at_limit)
  );

`ifdef IMEM_DMEM_ARBITER_ALIGN_CHECK_EN
  logic if_err_q;
  logic d_err_q;

  assign misalign = any_gnt && (granted_addr[1:0] != 2'b00);

  // Error flags ride alongside the owner tag; a misaligned store still
  // reports d_err even though it never produces a d_rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
    end else begin
      if_err_q <= if_gnt & misalign;
      d_err_q  <= d_gnt & misalign;
    end
  end

  assign if_bad     = if_err_q;
  assign d_bad      = d_err_q;
  assign bus.if_err = if_err_q;
  assign bus.d_err  = d_err_q;
`else
  assign misalign = 1'b0;
  assign if_bad   = 1'b0;
  assign d_bad    = 1'b0;
`endif

  // Memory side is idle (all zero) whenever nothing is granted.
  assign bus.mem_en    = any_gnt & ~misalign;
  assign bus.mem_we    = bus.mem_en & d_gnt & bus.d_we;
  assign bus.mem_addr  = any_gnt ? AW'(word_addr(granted_addr, AW)) : '0;
  assign bus.mem_wdata = d_gnt ? bus.d_wdata : '0;
  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;

  // Stores never own a return slot.
  always_comb begin
    tag_next = OWN_NONE;
    if (if_gnt) begin
      tag_next = OWN_IF;
    end else if (d_gnt && !bus.d_we) begin
      tag_next = OWN_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag <= OWN_NONE;
    end else begin
      tag <= tag_next;
    end
  end

  assign bus.if_rvalid = (tag == OWN_IF);
  assign bus.d_rvalid  = (tag == OWN_D);

  // mem_rdata only becomes valid in the return cycle, so it is passed straight
  // through then and captured so rdata holds while rvalid is low.
  assign if_rdata_now = if_bad ? 32'd0 : bus.mem_rdata;
  assign d_rdata_now  = d_bad  ? 32'd0 : bus.mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (bus.if_rvalid) begin
        if_rdata_q <= if_rdata_now;
      end
      if (bus.d_rvalid) begin
        d_rdata_q <= d_rdata_now;
      end
    end
  end

  assign bus.if_rdata = bus.if_rvalid ? if_rdata_now : if_rdata_q;
  assign bus.d_rdata  = bus.d_rvalid  ? d_rdata_now  : d_rdata_q;

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port, word-addressed program/data memory between two requesters: the instruction-fetch port (IF) and the load/store port (D).
- The memory is a ROM/RAM with a 1-cycle synchronous read.
- Arbitrates per cycle, issues one memory access per cycle, and routes read data back with a 1-cycle valid.
- Sits between the core's fetch/LSU and the instruction/data memory in the multi-cycle/pipelined RV32I variants.

Parameters:
- AW, 8, memory word-address width; byte address bits [AW+1:2] select the word.
- MAX_STREAK, 4, consecutive D grants allowed while IF is waiting before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch data valid, registered.
- if_rdata  out  32  fetch data; qualified by if_rvalid.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data access accepted (combinational).
- d_rvalid  out  1  load data valid, registered; never set for stores.
- d_rdata  out  32  load data; qualified by d_rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after a read with mem_en=1.

Behaviour:
- Reset (asynchronous, active-high):
  - if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0.
  - Owner tag = OWN_NONE, streak counter = 0.
  - mem_* outputs follow the grant logic and are 0 while no request is present.
- Grant (combinational, at most one per cycle):
  - Only d_req: d_gnt=1.
  - Only if_req: if_gnt=1.
  - Both, streak < MAX_STREAK: d_gnt=1.
  - Both, streak == MAX_STREAK: if_gnt=1.
  - Neither: no grant, mem_en=0.
- Memory issue on the grant cycle:
  - mem_en=1, mem_addr = granted_addr[AW+1:2], mem_we = d_we & d_gnt, mem_wdata = d_wdata.
  - Address bits [1:0] and [31:AW+2] are ignored.
- Owner tag (registered each cycle):
  - OWN_IF if an IF read was granted.
  - OWN_D if a D read was granted.
  - OWN_NONE otherwise, including for stores.
- Read return, the cycle after the grant (latency 1):
  - Tag OWN_IF: if_rvalid=1, if_rdata = mem_rdata.
  - Tag OWN_D: d_rvalid=1, d_rdata = mem_rdata.
  - rvalid is a 1-cycle pulse.
  - rdata registers hold their last value when rvalid=0.
- Throughput: one grant per cycle. Back-to-back grants are legal, and the return for grant N coincides with grant N+1.
- Streak counter (4-bit):
  - +1 when d_gnt & if_req.
  - Cleared on if_gnt, or when if_req=0.
  - Saturates at MAX_STREAK.
- Requester deasserts req before its grant: the request is dropped with no side effect. No memory access occurs for it.
- Reset asserted mid-access: any pending rvalid is cancelled and the tag returns to OWN_NONE. A store granted in the reset cycle is not guaranteed to have been written.
- Memory assumption: mem_rdata is stable for the full return cycle. There is no backpressure on the return.

Optional Feature:
- Macro: IMEM_DMEM_ARBITER_ALIGN_CHECK_EN.
- When defined, adds output ports if_err (1 bit) and d_err (1 bit).
- A granted access with addr[1:0] != 0 is still granted, but mem_en is forced to 0 that cycle, so no memory access occurs.
- For a misaligned read, the next cycle gives the requester's rvalid=1, err=1 and rdata=0.
- For a misaligned store, d_err pulses 1 cycle after the grant and d_rvalid stays 0.
- When not defined: no err ports, and addr[1:0] are silently ignored.

Decomposition:
- Package imem_dmem_arb_pkg contains:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_IF, OWN_D}.
  - Localparam STREAK_W = 4.
  - Function word_addr(addr, AW) returning addr[AW+1:2].
- Optional sub-module arb_streak_cnt: the saturating fairness counter (inputs: inc, clr, limit; output: at_limit).
- All other logic is inline.

Test Plan:
- Idle: no requests for 5 cycles -> mem_en=0, both rvalid=0, tags OWN_NONE.
- Reads and return routing:
  - if_req with if_addr=0x0000_0010 -> same cycle if_gnt=1, mem_addr=4.
  - With mem_rdata=0x0010_0093, the next cycle gives if_rvalid=1 and if_rdata=0x0010_0093.
  - d_rvalid stays 0 throughout.
- Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0xDEAD_BEEF -> mem_en=1, mem_we=1, mem_addr=8, mem_wdata=0xDEAD_BEEF; the next cycle gives d_rvalid=0.
- Fairness with MAX_STREAK=4: if_req and d_req held high continuously -> grant pattern D,D,D,D,IF repeating; if_rvalid every 5th return cycle, d_rvalid on the other four.
- Reset: assert reset the cycle after a D read grant -> d_rvalid stays 0 and the streak counter is 0. The first grant after reset release follows normal priority.
- Alignment check (with IMEM_DMEM_ARBITER_ALIGN_CHECK_EN): d_req load, d_addr=0x22 -> d_gnt=1 and mem_en=0; the next cycle gives d_rvalid=1, d_err=1, d_rdata=0.
